// File: rtl/config_streamer.sv
// config_streamer
//   Accepts a parallel configuration frame and shifts it LSB first, one bit
//   per clock, into a tile's serial configuration chain.
//   - program_mode is high only while bits are being shifted.
//   - done pulses for one cycle after the last bit.
//   - All outputs are registered.
//
// Optional feature: define CFG_READBACK_EN to build readback capture.
//   - The bit returned on jtag_data_in in SHIFT cycle k lands in rb_word[k].
//   - rb_valid pulses together with done.
//   - Without the macro, rb_word and rb_valid are tied to zero.
//
// Parameters
//   CFG_WIDTH      bits per frame (2..1024)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   cfg_word       frame to transmit
//   cfg_valid      cfg_word valid
//   cfg_ready      streamer idle and able to accept a frame
//   jtag_data_out  serial bit toward the tile
//   program_mode   tile programming enable (high while shifting)
//   jtag_data_in   serial bit returned from the tile
//   done           one-cycle pulse at frame completion
//   rb_word        captured readback frame
//   rb_valid       one-cycle pulse when rb_word updates
module config_streamer #(
    parameter int unsigned CFG_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CFG_WIDTH-1:0] cfg_word,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 jtag_data_out,
    output logic                 program_mode,
    input  logic                 jtag_data_in,
    output logic                 done,
    output logic [CFG_WIDTH-1:0] rb_word,
    output logic                 rb_valid
);

    localparam int unsigned      CNT_W = $clog2(CFG_WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CFG_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nx;
    logic [CFG_WIDTH-1:0] sreg, sreg_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 ready_nx, data_nx, prog_nx, done_nx;
    logic                 accept, last_bit;

    assign accept   = cfg_valid & cfg_ready;
    assign last_bit = (cnt == LAST);

    // Outputs are computed one cycle ahead and registered with the state.
    // Because of this, bit 0 is loaded straight into jtag_data_out on
    // acceptance, and the shift register holds only the bits still to send.
    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        cnt_nx   = cnt;
        ready_nx = 1'b0;
        data_nx  = 1'b0;
        prog_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                ready_nx = 1'b1;
                if (accept) begin
                    state_nx = SHIFT;
                    sreg_nx  = cfg_word >> 1;
                    cnt_nx   = '0;
                    data_nx  = cfg_word[0];
                    prog_nx  = 1'b1;
                    ready_nx = 1'b0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx  = cnt + CNT_W'(1);
                    sreg_nx = sreg >> 1;
                    data_nx = sreg[0];
                    prog_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sreg          <= '0;
            cnt           <= '0;
            cfg_ready     <= 1'b0;
            jtag_data_out <= 1'b0;
            program_mode  <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            sreg          <= sreg_nx;
            cnt           <= cnt_nx;
            cfg_ready     <= ready_nx;
            jtag_data_out <= data_nx;
            program_mode  <= prog_nx;
            done          <= done_nx;
        end
    end

`ifdef CFG_READBACK_EN
    logic [CFG_WIDTH-1:0] rb_shift;

    // Returned bits enter at the MSB.
    // After CFG_WIDTH shifts, the cycle-0 bit sits at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_shift <= '0;
            rb_word  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == SHIFT) begin
                rb_shift <= {jtag_data_in, rb_shift[CFG_WIDTH-1:1]};
                if (last_bit) begin
                    rb_word  <= {jtag_data_in, rb_shift[CFG_WIDTH-1:1]};
                    rb_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_jtag_data_in;

    assign unused_jtag_data_in = jtag_data_in;
    assign rb_word             = '0;
    assign rb_valid            = 1'b0;
`endif

endmodule

// File: doc/config_streamer.md
CONFIG_STREAMER -- requirements
Module: config_streamer

Interface
- REQ-001 SHALL have parameter CFG_WIDTH, default 64: number of configuration bits per frame, legal range 2..1024.
- REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-003 SHALL have port rst, input, 1: reset; synchronous, active-high.
- REQ-004 SHALL have port cfg_word, input, CFG_WIDTH: parallel configuration frame to transmit.
- REQ-005 SHALL have port cfg_valid, input, 1: cfg_word valid.
- REQ-006 SHALL have port cfg_ready, output, 1: streamer can accept a frame.
- REQ-007 SHALL have port jtag_data_out, output, 1: serial configuration bit toward the tile's jtag_data_in.
- REQ-008 SHALL have port program_mode, output, 1: tile programming enable, high only while bits are streamed.
- REQ-009 SHALL have port jtag_data_in, input, 1: serial bit returned from the tile's jtag_data_out.
- REQ-010 SHALL have port done, output, 1: one-cycle pulse at frame completion.
- REQ-011 SHALL have port rb_word, output, CFG_WIDTH: captured readback frame.
- REQ-012 SHALL have port rb_valid, output, 1: one-cycle pulse when rb_word updates.

Function
- REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
- REQ-014 SHALL drive cfg_ready=1 only in IDLE; a frame is accepted on a rising edge where cfg_valid=1 and cfg_ready=1.
- REQ-015 SHALL, on acceptance, latch cfg_word into an internal shift register, clear the bit counter, and enter SHIFT.
- REQ-016 SHALL, in SHIFT, drive program_mode=1 and jtag_data_out equal to frame bit k in the k-th SHIFT cycle (k=0..CFG_WIDTH-1), LSB first, one bit per clock.
- REQ-017 SHALL transmit each bit exactly as latched; later changes to cfg_word or cfg_valid during SHIFT/DONE have no effect.
- REQ-018 SHALL leave SHIFT for DONE after exactly CFG_WIDTH SHIFT cycles; the bit counter SHALL NOT wrap inside a frame.
- REQ-019 SHALL, in DONE, hold for exactly one cycle with done=1, program_mode=0, jtag_data_out=0, cfg_ready=0, then enter IDLE.
- REQ-020 SHALL, in IDLE, drive program_mode=0, jtag_data_out=0, done=0.
- REQ-021 SHALL give a minimum spacing of CFG_WIDTH+2 cycles between successive acceptances (accept, CFG_WIDTH shift cycles, DONE); cfg_valid held high continuously SHALL produce back-to-back frames at that rate.
- REQ-022 SHALL drive all outputs from registers (no combinational path from inputs to outputs).

Reset
- REQ-023 SHALL, while rst=1 on a rising edge, enter IDLE and clear the shift register, bit counter, rb_word, done, rb_valid, program_mode and jtag_data_out; cfg_ready SHALL be 0 during the reset cycle and 1 the first cycle after rst falls.
- REQ-024 SHALL, on reset mid-SHIFT or in DONE, abort the frame with no done or rb_valid pulse; the partially sent frame is discarded.
- REQ-025 SHALL have rst take priority over a simultaneous cfg_valid=1; that frame is not accepted.

Configuration
- REQ-026 SHALL use macro CFG_READBACK_EN to compile readback capture in or out.
- REQ-027 SHALL, with CFG_READBACK_EN defined, sample jtag_data_in in each SHIFT cycle k into rb_word[k], and pulse rb_valid together with done; rb_word SHALL be held until the next completed frame or reset.
- REQ-028 SHALL, without CFG_READBACK_EN, tie rb_word to 0 and rb_valid to 0, and leave jtag_data_in unused.

Verification
- REQ-029 SHALL verify single frame: CFG_WIDTH=64, cfg_word=64'h0000_0000_0000_0001 accepted at cycle 0 -> jtag_data_out=1 in cycle 1 and 0 in cycles 2..64, program_mode=1 in cycles 1..64, done=1 in cycle 65, cfg_ready=1 in cycle 66.
- REQ-030 SHALL verify pattern: cfg_word=64'h0000_0000_0086_4080 -> serial bits across 64 cycles reassemble LSB-first to 64'h0000_0000_0086_4080.
- REQ-031 SHALL verify back-to-back: cfg_valid held high with frames A=64'hFFFF_FFFF_FFFF_FFFF then B=64'h0 -> exactly 66 cycles between acceptances; B sends 64 zeros; cfg_word changes during A have no effect.
- REQ-032 SHALL verify reset abort: rst=1 in SHIFT cycle 20 -> program_mode=0, jtag_data_out=0 next cycle, no done pulse, cfg_ready=1 one cycle after rst falls.
- REQ-033 SHALL verify readback (CFG_READBACK_EN defined): jtag_data_in looped from jtag_data_out, cfg_word=64'hA5A5_0000_1234_5678 -> rb_word=64'hA5A5_0000_1234_5678 with rb_valid=1 in the done cycle.
- REQ-034 SHALL verify readback disabled (CFG_READBACK_EN undefined): same stimulus -> rb_word=0 and rb_valid=0 in every cycle.
